// File: rtl/rtc_bus_reader_pkg.sv
// Shared definitions for the RTC bus reader: register offsets, FSM encoding,
// range limits, retry bound and the binary-to-BCD helper.
package rtc_bus_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD_SEC,
    ST_RD_MIN,
    ST_RD_HOUR,
    ST_RD_SEC2,
    ST_CHECK,
    ST_COMMIT
  } state_t;

  localparam int OFF_SEC  = 'h0;
  localparam int OFF_MIN  = 'h4;
  localparam int OFF_HOUR = 'h8;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] HOUR_MAX = 6'd23;

  localparam logic [1:0] MAX_RETRY = 2'd2;

  // Two-digit BCD of a value already known to be below 64.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [7:0] r;
    r[7:4] = 4'(v / 6'd10);
    r[3:0] = 4'(v % 6'd10);
    return r;
  endfunction

endpackage

// File: rtl/rtc_bus_reader_poll_tick_gen.sv
// Poll interval counter: counts 0..POLL_DIV-1 while enabled and flags the
// last count as the start tick; held at zero while disabled.
module poll_tick_gen
  import rtc_bus_reader_pkg::*;
#(
  parameter int POLL_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(POLL_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_DIV - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (!enable) begin
      count_reg <= '0;
    end else if (count_reg == CNT_LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = enable && (count_reg == CNT_LAST);

endmodule

// File: rtl/rtc_bus_reader.sv
// Bus initiator that polls the RTC SEC/MIN/HOUR registers and commits a
// rollover-consistent, range-checked snapshot. Macro RTC_READER_BCD_EN adds BCD outputs.
module rtc_bus_reader
  import rtc_bus_reader_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RTC_BASE = 8'h00,
  parameter int                POLL_DIV = 100000,
  parameter int                RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              cs,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [5:0]        sec,
  output logic [5:0]        min,
  output logic [4:0]        hour,
  output logic              time_valid,
  output logic              upd,
  output logic              err
`ifdef RTC_READER_BCD_EN
  ,
  output logic [7:0]        bcd_sec,
  output logic [7:0]        bcd_min,
  output logic [7:0]        bcd_hour
`endif
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

  state_t      state_reg, state_next;
  logic [1:0]  phase_reg, phase_next;
  logic [1:0]  retry_reg, retry_next;
  logic [5:0]  cap_sec_reg, cap_min_reg, cap_hour_reg, cap_sec2_reg;
  logic [5:0]  sec_reg, min_reg;
  logic [4:0]  hour_reg;
  logic        time_valid_reg, upd_reg, err_reg;
  logic        tick, capture, do_commit, do_fail;
  logic        rd_state;
  logic [ADDR_W-1:0] rd_off;
  state_t      rd_after;
  logic        unused_rdata;

  assign unused_rdata = ^rdata[DATA_W-1:6];

  poll_tick_gen #(
    .POLL_DIV (POLL_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    retry_next = retry_reg;
    bus_req    = 1'b0;
    cs         = 1'b0;
    addr       = '0;
    capture    = 1'b0;
    do_commit  = 1'b0;
    do_fail    = 1'b0;
    rd_state   = 1'b0;
    rd_off     = '0;
    rd_after   = ST_IDLE;

    case (state_reg)
      ST_IDLE: begin
        if (tick) begin
          state_next = ST_REQ;
          retry_next = '0;
        end
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          state_next = ST_RD_SEC;
          phase_next = '0;
        end
      end
      ST_RD_SEC: begin
        rd_state = 1'b1;
        rd_off   = ADDR_W'(OFF_SEC);
        rd_after = ST_RD_MIN;
      end
      ST_RD_MIN: begin
        rd_state = 1'b1;
        rd_off   = ADDR_W'(OFF_MIN);
        rd_after = ST_RD_HOUR;
      end
      ST_RD_HOUR: begin
        rd_state = 1'b1;
        rd_off   = ADDR_W'(OFF_HOUR);
        rd_after = ST_RD_SEC2;
      end
      ST_RD_SEC2: begin
        rd_state = 1'b1;
        rd_off   = ADDR_W'(OFF_SEC);
        rd_after = ST_CHECK;
      end
      ST_CHECK: begin
        bus_req = 1'b1;
        // Differing SEC reads mean a carry rippled through mid-snapshot.
        if (cap_sec2_reg != cap_sec_reg) begin
          if (retry_reg < MAX_RETRY) begin
            retry_next = retry_reg + 1'b1;
            phase_next = '0;
            state_next = ST_RD_SEC;
          end else begin
            retry_next = '0;
            do_fail    = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (cap_sec_reg > SEC_MAX || cap_min_reg > MIN_MAX ||
                     cap_hour_reg > HOUR_MAX) begin
          retry_next = '0;
          do_fail    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          do_commit  = 1'b1;
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        retry_next = '0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Losing the grant at any phase abandons the read; it is reissued from phase 0.
    if (rd_state) begin
      bus_req = 1'b1;
      if (!bus_gnt) begin
        phase_next = '0;
      end else if (phase_reg == 2'd0) begin
        cs         = 1'b1;
        addr       = RTC_BASE + rd_off;
        phase_next = 2'd1;
      end else if (phase_reg == LAT_LAST) begin
        capture    = 1'b1;
        phase_next = '0;
        state_next = rd_after;
      end else begin
        phase_next = phase_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      phase_reg      <= '0;
      retry_reg      <= '0;
      cap_sec_reg    <= '0;
      cap_min_reg    <= '0;
      cap_hour_reg   <= '0;
      cap_sec2_reg   <= '0;
      sec_reg        <= '0;
      min_reg        <= '0;
      hour_reg       <= '0;
      time_valid_reg <= 1'b0;
      upd_reg        <= 1'b0;
      err_reg        <= 1'b0;
`ifdef RTC_READER_BCD_EN
      bcd_sec        <= '0;
      bcd_min        <= '0;
      bcd_hour       <= '0;
`endif
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      retry_reg <= retry_next;
      upd_reg   <= do_commit;
      err_reg   <= do_fail;
      if (capture) begin
        case (state_reg)
          ST_RD_SEC:  cap_sec_reg  <= rdata[5:0];
          ST_RD_MIN:  cap_min_reg  <= rdata[5:0];
          ST_RD_HOUR: cap_hour_reg <= rdata[5:0];
          default:    cap_sec2_reg <= rdata[5:0];
        endcase
      end
      // Outputs load on the edge into COMMIT so they are valid alongside upd.
      if (do_commit) begin
        sec_reg        <= cap_sec_reg;
        min_reg        <= cap_min_reg;
        hour_reg       <= cap_hour_reg[4:0];
        time_valid_reg <= 1'b1;
`ifdef RTC_READER_BCD_EN
        bcd_sec        <= to_bcd(cap_sec_reg);
        bcd_min        <= to_bcd(cap_min_reg);
        bcd_hour       <= to_bcd(cap_hour_reg);
`endif
      end
    end
  end

  assign wr         = 1'b0;
  assign wdata      = '0;
  assign sec        = sec_reg;
  assign min        = min_reg;
  assign hour       = hour_reg;
  assign time_valid = time_valid_reg;
  assign upd        = upd_reg;
  assign err        = err_reg;

endmodule
